// File: rtl/onewire_temp_sequencer.sv
// Drives the 1-Wire master through reset/skip/convert/wait/reset/skip/read-scratchpad
// and returns the raw temperature word. Define ONEWIRE_CRC_EN to verify the scratchpad CRC-8.
module onewire_temp_sequencer #(
  parameter int CONV_CYCLES = 37500000,
  parameter int OP_TIMEOUT  = 100000
) (
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic        start_i,
  output logic [2:0]  cmd_o,
  output logic [7:0]  data_in_o,
  input  logic [63:0] data_out_i,
  input  logic [7:0]  status_i,
  output logic        busy_o,
  output logic        done_o,
  output logic [1:0]  err_o,
  output logic [15:0] temp_o
);

  localparam int CONV_W = $clog2(CONV_CYCLES + 1);
  localparam int TMO_W  = $clog2(OP_TIMEOUT + 1);

  localparam logic [2:0] CMD_NOP   = 3'd0;
  localparam logic [2:0] CMD_RESET = 3'd1;
  localparam logic [2:0] CMD_WRITE = 3'd2;
  localparam logic [2:0] CMD_READ  = 3'd3;

  typedef enum logic [3:0] {
    IDLE, RST1, SKIP1, CONV, WAIT_CONV, RST2, SKIP2, RDSP, RDBYTE, CHECK, FINISH
  } state_e;

  state_e            state_q, state_d;
  logic              wait_q, wait_d;
  logic [TMO_W-1:0]  tmo_q, tmo_d;
  logic [CONV_W-1:0] conv_q, conv_d;
  logic [3:0]        idx_q, idx_d;
  logic [7:0]        byte0_q, byte0_d;
  logic [7:0]        byte1_q, byte1_d;
  logic [1:0]        err_q, err_d;
  logic [15:0]       temp_q, temp_d;

  logic [2:0]        op_cmd;
  logic [7:0]        op_byte;
  logic              op_done;
  logic              crc_ok;

  // Only the low result byte, done and presence are consumed from the master.
  logic unused_bits;
  assign unused_bits = ^{data_out_i[63:8], status_i[7:3], status_i[0]};

`ifdef ONEWIRE_CRC_EN
  logic [7:0] crc_q, crc_d;

  function automatic logic [7:0] crc8_update(input logic [7:0] crc, input logic [7:0] data);
    logic [7:0] c;
    c = crc;
    for (int i = 0; i < 8; i++) begin
      if (c[0] ^ data[i]) c = (c >> 1) ^ 8'h8C;
      else                c = c >> 1;
    end
    return c;
  endfunction

  assign crc_ok = (crc_q == 8'h00);
`else
  assign crc_ok = 1'b1;
`endif

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q <= IDLE;
      wait_q  <= 1'b0;
      tmo_q   <= '0;
      conv_q  <= '0;
      idx_q   <= '0;
      byte0_q <= '0;
      byte1_q <= '0;
      err_q   <= '0;
      temp_q  <= '0;
`ifdef ONEWIRE_CRC_EN
      crc_q   <= '0;
`endif
    end else begin
      state_q <= state_d;
      wait_q  <= wait_d;
      tmo_q   <= tmo_d;
      conv_q  <= conv_d;
      idx_q   <= idx_d;
      byte0_q <= byte0_d;
      byte1_q <= byte1_d;
      err_q   <= err_d;
      temp_q  <= temp_d;
`ifdef ONEWIRE_CRC_EN
      crc_q   <= crc_d;
`endif
    end
  end

  always_comb begin
    state_d   = state_q;
    wait_d    = wait_q;
    tmo_d     = tmo_q;
    conv_d    = conv_q;
    idx_d     = idx_q;
    byte0_d   = byte0_q;
    byte1_d   = byte1_q;
    err_d     = err_q;
    temp_d    = temp_q;
`ifdef ONEWIRE_CRC_EN
    crc_d     = crc_q;
`endif
    cmd_o     = CMD_NOP;
    data_in_o = 8'h00;
    done_o    = 1'b0;
    op_cmd    = CMD_NOP;
    op_byte   = 8'h00;
    op_done   = 1'b0;

    case (state_q)
      IDLE: begin
        if (start_i) begin
          err_d   = 2'd0;
          wait_d  = 1'b0;
          state_d = RST1;
        end
      end
      RST1, RST2:   op_cmd = CMD_RESET;
      SKIP1, SKIP2: begin op_cmd = CMD_WRITE; op_byte = 8'hCC; end
      CONV:         begin op_cmd = CMD_WRITE; op_byte = 8'h44; end
      RDSP:         begin op_cmd = CMD_WRITE; op_byte = 8'hBE; end
      RDBYTE:       op_cmd = CMD_READ;
      WAIT_CONV: begin
        if (conv_q == '0) state_d = RST2;
        else              conv_d  = conv_q - CONV_W'(1);
      end
      CHECK: begin
        if (crc_ok) temp_d = {byte1_q, byte0_q};
        else        err_d  = 2'd3;
        state_d = FINISH;
      end
      FINISH: begin
        done_o  = 1'b1;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase

    // Shared handshake: one ISSUE cycle with the command, then wait for done or time out.
    if (op_cmd != CMD_NOP) begin
      if (!wait_q) begin
        cmd_o     = op_cmd;
        data_in_o = op_byte;
        wait_d    = 1'b1;
        tmo_d     = '0;
      end else if (status_i[1]) begin
        wait_d  = 1'b0;
        op_done = 1'b1;
      end else if (tmo_q == TMO_W'(OP_TIMEOUT - 1)) begin
        wait_d  = 1'b0;
        err_d   = 2'd2;
        state_d = FINISH;
      end else begin
        tmo_d = tmo_q + TMO_W'(1);
      end
    end

    if (op_done) begin
      case (state_q)
        RST1, RST2: begin
          if (!status_i[2]) begin
            err_d   = 2'd1;
            state_d = FINISH;
          end else begin
            state_d = (state_q == RST1) ? SKIP1 : SKIP2;
          end
        end
        SKIP1: state_d = CONV;
        CONV: begin
          conv_d  = CONV_W'(CONV_CYCLES);
          state_d = WAIT_CONV;
        end
        SKIP2: state_d = RDSP;
        RDSP: begin
          idx_d   = '0;
`ifdef ONEWIRE_CRC_EN
          crc_d   = 8'h00;
`endif
          state_d = RDBYTE;
        end
        RDBYTE: begin
          if (idx_q == 4'd0) byte0_d = data_out_i[7:0];
          if (idx_q == 4'd1) byte1_d = data_out_i[7:0];
`ifdef ONEWIRE_CRC_EN
          crc_d = crc8_update(crc_q, data_out_i[7:0]);
`endif
          if (idx_q == 4'd8) state_d = CHECK;
          else               idx_d   = idx_q + 4'd1;
        end
        default: ;
      endcase
    end
  end

  assign busy_o = (state_q != IDLE) && (state_q != FINISH);
  assign err_o  = err_q;
  assign temp_o = temp_q;

endmodule

// File: tb/tb_onewire_temp_sequencer.sv
// Directed bench for onewire_temp_sequencer with a reactive 1-Wire master model;
// CRC expectations follow ONEWIRE_CRC_EN.
module tb_onewire_temp_sequencer;

  localparam int CONV_CYCLES = 20;
  localparam int OP_TIMEOUT  = 50;

  logic        clk_i = 1'b0;
  logic        rst_i;
  logic        start_i;
  logic [2:0]  cmd_o;
  logic [7:0]  data_in_o;
  logic [63:0] data_out_i = 64'h0;
  logic [7:0]  status_i = 8'h00;
  logic        busy_o;
  logic        done_o;
  logic [1:0]  err_o;
  logic [15:0] temp_o;

  int checks = 0;
  int errors = 0;

  logic [7:0] scratch [9];
  bit         presence = 1'b1;
  int         hang_at = -1;
  int         cmd_count = 0;
  int         done_count = 0;
  int         cyc = 0;
  int         pend = 0;
  int         rd_idx = 0;
  logic [2:0] last_cmd = 3'd0;
  logic [2:0] cmd_log [$];
  logic [7:0] byte_log [$];
  int         issue_cyc [$];

  onewire_temp_sequencer #(
    .CONV_CYCLES(CONV_CYCLES),
    .OP_TIMEOUT (OP_TIMEOUT)
  ) dut (
    .clk_i     (clk_i),
    .rst_i     (rst_i),
    .start_i   (start_i),
    .cmd_o     (cmd_o),
    .data_in_o (data_in_o),
    .data_out_i(data_out_i),
    .status_i  (status_i),
    .busy_o    (busy_o),
    .done_o    (done_o),
    .err_o     (err_o),
    .temp_o    (temp_o)
  );

  always #5 clk_i = ~clk_i;

  always @(posedge clk_i) cyc++;

  always @(negedge clk_i) if (done_o) done_count++;

  // Master model: completes each command two negedges after seeing it, unless told to hang.
  always @(negedge clk_i) begin
    if (rst_i) begin
      pend     = 0;
      status_i = 8'h00;
    end else begin
      status_i[1] = 1'b0;
      if (pend > 0) begin
        pend--;
        if (pend == 0) begin
          status_i[1] = 1'b1;
          status_i[2] = presence;
          if (last_cmd == 3'd3) begin
            data_out_i = {56'hDEADBEEF012345, scratch[rd_idx]};
            rd_idx++;
          end
        end
      end
      if (cmd_o != 3'd0) begin
        cmd_log.push_back(cmd_o);
        byte_log.push_back(data_in_o);
        issue_cyc.push_back(cyc);
        last_cmd = cmd_o;
        if (cmd_o == 3'd1) rd_idx = 0;
        if (cmd_count != hang_at) pend = 2;
        cmd_count++;
      end
      status_i[0] = (pend > 0);
    end
  end

  task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    checks++;
    assert (observed === expected) else begin
      errors++;
      $error("[TB] FAIL %s observed=%0h expected=%0h", tag, observed, expected);
    end
  endtask

  task automatic applyStimulus();
    start_i = 1'b1;
    @(posedge clk_i); #1;
    start_i = 1'b0;
  endtask

  task automatic waitDone(input int limit, input string tag);
    bit seen;
    seen = 1'b0;
    for (int i = 0; i < limit && !seen; i++) begin
      @(posedge clk_i); #1;
      if (done_o) seen = 1'b1;
    end
    checkOutput({tag, "_done_seen"}, 32'(seen), 32'd1);
  endtask

  task automatic checkSequence(input int base, input string tag);
    logic [2:0] ec [15];
    logic [7:0] eb [15];
    ec = '{3'd1, 3'd2, 3'd2, 3'd1, 3'd2, 3'd2, 3'd3, 3'd3, 3'd3,
           3'd3, 3'd3, 3'd3, 3'd3, 3'd3, 3'd3};
    eb = '{8'h00, 8'hCC, 8'h44, 8'h00, 8'hCC, 8'hBE, 8'h00, 8'h00, 8'h00,
           8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00};
    for (int i = 0; i < 15; i++)
      checkOutput($sformatf("%s_seq%0d", tag, i),
                  {21'd0, cmd_log[base + i], byte_log[base + i]},
                  {21'd0, ec[i], eb[i]});
  endtask

  task automatic loadGood();
    scratch = '{8'h50, 8'h05, 8'h4B, 8'h46, 8'h7F, 8'hFF, 8'h0C, 8'h10, 8'h1C};
  endtask

  initial begin
    #200000;
    $display("[TB] FAIL watchdog expired observed=running expected=finished");
    $fatal(1, "[TB] watchdog");
  end

  initial begin
    int base;
    int dbase;
    int delta;
    bit reached;
    logic [1:0]  crc_err_exp;
    logic [15:0] crc_temp_exp;

    rst_i   = 1'b1;
    start_i = 1'b0;
    loadGood();
    repeat (3) @(posedge clk_i);
    #1;
    checkOutput("rst_cmd",     32'(cmd_o),     32'd0);
    checkOutput("rst_data_in", 32'(data_in_o), 32'd0);
    checkOutput("rst_busy",    32'(busy_o),    32'd0);
    checkOutput("rst_done",    32'(done_o),    32'd0);
    checkOutput("rst_err",     32'(err_o),     32'd0);
    checkOutput("rst_temp",    32'(temp_o),    32'd0);
    rst_i = 1'b0;
    @(posedge clk_i); #1;

    // No presence pulse on the first reset
    presence = 1'b0;
    base  = cmd_count;
    dbase = done_count;
    applyStimulus();
    checkOutput("np_busy", 32'(busy_o), 32'd1);
    waitDone(50, "np");
    checkOutput("np_err",  32'(err_o),  32'd1);
    checkOutput("np_temp", 32'(temp_o), 32'd0);
    checkOutput("np_busy_fin", 32'(busy_o), 32'd0);
    @(posedge clk_i); #1;
    checkOutput("np_cmds",  32'(cmd_count - base),   32'd1);
    checkOutput("np_dones", 32'(done_count - dbase), 32'd1);
    presence = 1'b1;

    // Good read, with start pulses mid-sequence and on the FINISH cycle
    base  = cmd_count;
    dbase = done_count;
    applyStimulus();
    checkOutput("good_err_clear", 32'(err_o), 32'd0);
    repeat (5) @(posedge clk_i);
    #1;
    applyStimulus();
    waitDone(300, "good");
    checkOutput("good_err",  32'(err_o),  32'd0);
    checkOutput("good_temp", 32'(temp_o), 32'h0550);
    checkOutput("good_busy_fin", 32'(busy_o), 32'd0);
    start_i = 1'b1;
    @(posedge clk_i); #1;
    start_i = 1'b0;
    repeat (3) @(posedge clk_i);
    #1;
    checkOutput("good_busy_after", 32'(busy_o), 32'd0);
    checkOutput("good_cmds",  32'(cmd_count - base),   32'd15);
    checkOutput("good_dones", 32'(done_count - dbase), 32'd1);
    checkSequence(base, "good");

    // Corrupted CRC byte
`ifdef ONEWIRE_CRC_EN
    scratch[8]   = 8'h1D;
    crc_err_exp  = 2'd3;
    crc_temp_exp = 16'h0550;
`else
    scratch[0]   = 8'h60;
    scratch[1]   = 8'h01;
    scratch[8]   = 8'h1D;
    crc_err_exp  = 2'd0;
    crc_temp_exp = 16'h0160;
`endif
    applyStimulus();
    waitDone(300, "crc");
    checkOutput("crc_err",  32'(err_o),  32'(crc_err_exp));
    checkOutput("crc_temp", 32'(temp_o), 32'(crc_temp_exp));
    loadGood();
    repeat (2) @(posedge clk_i);
    #1;

    // Master never completes the convert write
    base    = cmd_count;
    hang_at = base + 2;
    applyStimulus();
    waitDone(300, "tmo");
    checkOutput("tmo_err",  32'(err_o),  32'd2);
    checkOutput("tmo_cmd",  32'(cmd_o),  32'd0);
    checkOutput("tmo_temp", 32'(temp_o), 32'(crc_temp_exp));
    checkOutput("tmo_cmds", 32'(cmd_count - base), 32'd3);
    delta = cyc - issue_cyc[base + 2];
    checkOutput("tmo_window", 32'(delta >= OP_TIMEOUT && delta <= OP_TIMEOUT + 2), 32'd1);
    hang_at = -1;
    repeat (2) @(posedge clk_i);
    #1;

    // Reset while waiting for the conversion
    base = cmd_count;
    applyStimulus();
    reached = 1'b0;
    for (int i = 0; i < 100 && !reached; i++) begin
      @(posedge clk_i); #1;
      if (cmd_count == base + 3) reached = 1'b1;
    end
    checkOutput("wc_reached_conv", 32'(reached), 32'd1);
    repeat (8) @(posedge clk_i);
    #1;
    checkOutput("wc_busy_pre", 32'(busy_o), 32'd1);
    checkOutput("wc_cmds_pre", 32'(cmd_count - base), 32'd3);
    rst_i = 1'b1;
    @(posedge clk_i); #1;
    checkOutput("wc_rst_cmd",  32'(cmd_o),  32'd0);
    checkOutput("wc_rst_busy", 32'(busy_o), 32'd0);
    checkOutput("wc_rst_temp", 32'(temp_o), 32'd0);
    checkOutput("wc_rst_err",  32'(err_o),  32'd0);
    rst_i = 1'b0;
    @(posedge clk_i); #1;

    // Clean full sequence after the abort
    base  = cmd_count;
    dbase = done_count;
    applyStimulus();
    waitDone(300, "post");
    checkOutput("post_err",  32'(err_o),  32'd0);
    checkOutput("post_temp", 32'(temp_o), 32'h0550);
    repeat (2) @(posedge clk_i);
    #1;
    checkOutput("post_cmds",  32'(cmd_count - base),   32'd15);
    checkOutput("post_dones", 32'(done_count - dbase), 32'd1);
    checkSequence(base, "post");

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
